uart_rx_drain_ctrl: RTL and testbench

Sequencer between the UART receiver's RX FIFO and the downstream consumer (bus slave or DMA stream). It pops received characters from the FWFT FIFO, holds each one in an output register behind a valid/ready handshake, and accumulates sticky error status and a saturating error count. It also mediates the receiver's SYN-triggered configuration request: it interrupts the host and returns the request acknowledge only after the output register has drained.

---
 rtl/uart_rx_drain_ctrl_pkg.sv | 18 +
 rtl/uart_err_accum.sv | 48 ++++
 rtl/uart_rx_drain_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_drain_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_drain_ctrl_pkg.sv
// Shared types and constants for the UART RX drain sequencer.
package uart_rx_drain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    CFG_WAIT = 2'd3
  } state_e;

  // Bit positions inside every 3-bit error vector: {parity, overrun, frame}.
  localparam int unsigned FRAME   = 0;
  localparam int unsigned OVERRUN = 1;
  localparam int unsigned PARITY  = 2;

  localparam int unsigned ERR_W = 3;

endpackage

// File: rtl/uart_err_accum.sv
// Sticky error status plus saturating error-character counter.
// A clear and a set in the same cycle: the set wins (status bit set, count = 1).
module uart_err_accum #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 upd_i,
  input  logic [2:0]           flags_i,
  input  logic                 clear_i,
  output logic [2:0]           status_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [2:0]           status_q, status_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, count_base;
  logic                 hit;

  assign hit = upd_i & (|flags_i);

  // Clear first, then apply this cycle's flags on top of the cleared value.
  always_comb begin
    status_d   = clear_i ? 3'b000 : status_q;
    count_base = clear_i ? '0 : count_q;
    count_d    = count_base;
    if (upd_i) begin
      status_d = status_d | flags_i;
    end
    if (hit && (count_base != {CNT_WIDTH{1'b1}})) begin
      count_d = count_base + CNT_WIDTH'(1);
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      status_q <= 3'b000;
      count_q  <= '0;
    end else begin
      status_q <= status_d;
      count_q  <= count_d;
    end
  end

  assign status_o = status_q;
  assign count_o  = count_q;

endmodule

// File: rtl/uart_rx_drain_ctrl.sv
// Drains the UART RX FWFT FIFO into a valid/ready holding register and
// mediates the receiver's configuration request toward the host.
// Optional feature macro: UART_RX_ERR_DROP_EN (drop characters with errors).
//
// state    | meaning
// IDLE     | waiting for config request or a non-empty FIFO
// FETCH    | pop strobe this cycle, character captured at the edge
// HOLD     | character held on data_o until data_ready_i
// CFG_WAIT | cfg_irq_o raised, waiting for host ack or request withdrawal
module uart_rx_drain_ctrl
  import uart_rx_drain_ctrl_pkg::*;
#(
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     enable_i,
  input  logic                     rx_fifo_empty_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     frame_error_i,
  input  logic                     parity_error_i,
  input  logic                     overrun_error_i,
  output logic                     rx_fifo_read_o,
  input  logic                     config_req_i,
  output logic                     request_ack_o,
  input  logic                     cfg_ack_i,
  output logic [7:0]               data_o,
  output logic [2:0]               data_err_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  input  logic                     err_clear_i,
  output logic [2:0]               err_status_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic                     cfg_irq_o,
  output logic                     irq_o
);

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ack_q, ack_d;
  logic [ERR_W-1:0] flags;
  logic            fetch_ok;

  assign flags[FRAME]   = frame_error_i;
  assign flags[OVERRUN] = overrun_error_i;
  assign flags[PARITY]  = parity_error_i;
  assign fetch_ok       = enable_i & ~rx_fifo_empty_i;

`ifndef UART_RX_ERR_DROP_EN
  logic [2:0] data_err_q, data_err_d;
`endif

  // Next-state and holding-register update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
`ifndef UART_RX_ERR_DROP_EN
    data_err_d = data_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (config_req_i) begin
          state_d = CFG_WAIT;
        end else if (fetch_ok) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
`ifdef UART_RX_ERR_DROP_EN
        // Dropped characters return through IDLE: the FIFO's empty flag does
        // not reflect this pop until next cycle, so a direct re-fetch could
        // pop an empty FIFO.
        if (|flags) begin
          state_d = IDLE;
        end else begin
          data_d  = rx_data_i;
          valid_d = 1'b1;
          state_d = HOLD;
        end
`else
        data_d     = rx_data_i;
        data_err_d = flags;
        valid_d    = 1'b1;
        state_d    = HOLD;
`endif
      end
      HOLD: begin
        if (data_ready_i) begin
          valid_d = 1'b0;
          if (config_req_i) begin
            state_d = CFG_WAIT;
          end else if (fetch_ok) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CFG_WAIT: begin
        if (cfg_ack_i) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end else if (!config_req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, holding register and acknowledge pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
`ifndef UART_RX_ERR_DROP_EN
      data_err_q <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
`ifndef UART_RX_ERR_DROP_EN
      data_err_q <= data_err_d;
`endif
    end
  end

  uart_err_accum #(
    .CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_err_accum (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .upd_i    (state_q == FETCH),
    .flags_i  (flags),
    .clear_i  (err_clear_i),
    .status_o (err_status_o),
    .count_o  (err_count_o)
  );

  assign rx_fifo_read_o = (state_q == FETCH);
  assign cfg_irq_o      = (state_q == CFG_WAIT);
  assign request_ack_o  = ack_q;
  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
`ifdef UART_RX_ERR_DROP_EN
  assign data_err_o     = 3'b000;
`else
  assign data_err_o     = data_err_q;
`endif
  assign irq_o          = cfg_irq_o | (|err_status_o);

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Directed bench: FIFO model feeding two instances (8-bit and 2-bit error counters).
module tb_uart_rx_drain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, empty, frame_e, parity_e, overrun_e;
  logic [7:0] rx_data;
  logic       config_req, cfg_ack, data_ready, err_clear;

  logic       rd, ack, valid, cfg_irq, irq;
  logic [7:0] data;
  logic [2:0] derr, status;
  logic [7:0] count;

  logic       n_rd, n_ack, n_valid, n_cfg_irq, n_irq;
  logic [7:0] n_data;
  logic [2:0] n_derr, n_status;
  logic [1:0] n_count;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int ack_cnt = 0;
  int illegal = 0;
  int pops_base;

  logic [10:0] fifo[$];
  logic [7:0]  recv_d[$];
  logic [2:0]  recv_e[$];

  uart_rx_drain_ctrl #(.ERR_CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .rx_fifo_empty_i(empty),
    .rx_data_i(rx_data), .frame_error_i(frame_e), .parity_error_i(parity_e),
    .overrun_error_i(overrun_e), .rx_fifo_read_o(rd), .config_req_i(config_req),
    .request_ack_o(ack), .cfg_ack_i(cfg_ack), .data_o(data), .data_err_o(derr),
    .data_valid_o(valid), .data_ready_i(data_ready), .err_clear_i(err_clear),
    .err_status_o(status), .err_count_o(count), .cfg_irq_o(cfg_irq), .irq_o(irq)
  );

  uart_rx_drain_ctrl #(.ERR_CNT_WIDTH(2)) dut_narrow (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .rx_fifo_empty_i(empty),
    .rx_data_i(rx_data), .frame_error_i(frame_e), .parity_error_i(parity_e),
    .overrun_error_i(overrun_e), .rx_fifo_read_o(n_rd), .config_req_i(config_req),
    .request_ack_o(n_ack), .cfg_ack_i(cfg_ack), .data_o(n_data), .data_err_o(n_derr),
    .data_valid_o(n_valid), .data_ready_i(data_ready), .err_clear_i(err_clear),
    .err_status_o(n_status), .err_count_o(n_count), .cfg_irq_o(n_cfg_irq), .irq_o(n_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_recv(input string tag, input int idx, input logic [7:0] exp_d,
                            input logic [2:0] exp_e);
    logic [31:0] obs;
    obs = (idx < recv_d.size()) ? {21'd0, recv_e[idx], recv_d[idx]} : 32'hxxxxxxxx;
    check(tag, obs, {21'd0, exp_e, exp_d});
  endtask

  task automatic present();
    logic [10:0] head;
    empty = (fifo.size() == 0);
    head  = (fifo.size() != 0) ? fifo[0] : 11'd0;
    rx_data   = head[7:0];
    frame_e   = head[8];
    overrun_e = head[9];
    parity_e  = head[10];
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] f);
    fifo.push_back({f, d});
    present();
  endtask

  task automatic step();
    logic popped;
    popped = rd;
    if (rd && (empty || valid)) illegal++;
    if (valid && data_ready) begin
      recv_d.push_back(data);
      recv_e.push_back(derr);
    end
    @(posedge clk);
    #1;
    if (popped && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    if (ack) ack_cnt++;
    present();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; config_req = 1'b0; cfg_ack = 1'b0;
    data_ready = 1'b0; err_clear = 1'b0;
    present();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_outputs",
          {rd, ack, data, derr, valid, status, count, cfg_irq, irq},
          32'd0);
    check("reset_narrow_count", {30'd0, n_count}, 32'd0);
    rst_n = 1'b1; enable = 1'b1; data_ready = 1'b1;

    // Single character
    push(8'hA5, 3'b000);
    check("single_idle_no_read", rd, 0);
    step();
    check("single_fetch_read", {rd, valid}, 2'b10);
    step();
    check("single_hold", {rd, valid, derr, data}, {1'b0, 1'b1, 3'b000, 8'hA5});
    check("single_pops", pops, 1);
    step();
    check("single_valid_one_cycle", valid, 0);
    check_recv("single_recv", 0, 8'hA5, 3'b000);

    // Backpressure
    recv_d.delete(); recv_e.delete();
    data_ready = 1'b0;
    pops_base = pops;
    push(8'h01, 3'b000); push(8'h02, 3'b000); push(8'h03, 3'b000);
    run(2);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_stable", {valid, data}, {1'b1, 8'h01});
    end
    check("bp_one_pop", pops - pops_base, 1);
    data_ready = 1'b1;
    run(8);
    check("bp_count", recv_d.size(), 3);
    check_recv("bp_recv0", 0, 8'h01, 3'b000);
    check_recv("bp_recv1", 1, 8'h02, 3'b000);
    check_recv("bp_recv2", 2, 8'h03, 3'b000);
    check("bp_no_irq", irq, 0);

    // Error accumulation
    recv_d.delete(); recv_e.delete();
    push(8'h10, 3'b001); push(8'h20, 3'b100); push(8'h30, 3'b000);
    run(10);
    check("err_status", status, 3'b101);
    check("err_count", count, 2);
    check("err_irq", irq, 1);
`ifdef UART_RX_ERR_DROP_EN
    check("err_recv_n", recv_d.size(), 1);
    check_recv("err_recv0", 0, 8'h30, 3'b000);
`else
    check("err_recv_n", recv_d.size(), 3);
    check_recv("err_recv0", 0, 8'h10, 3'b001);
    check_recv("err_recv1", 1, 8'h20, 3'b100);
    check_recv("err_recv2", 2, 8'h30, 3'b000);
`endif

    // Clear colliding with an overrun character
    push(8'h40, 3'b010);
    step();
    check("clr_fetch", rd, 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("clr_status", status, 3'b010);
    check("clr_count", count, 1);
    check("clr_narrow_count", n_count, 1);
    run(4);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 3'b001);
    run(16);
    check("sat_wide_count", count, 6);
    check("sat_narrow_count", n_count, 3);
    check("sat_status", status, 3'b011);

    // Mixed stream through the drop/forward path
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("plain_clear", {irq, status, count}, 12'd0);
    recv_d.delete(); recv_e.delete();
    push(8'h11, 3'b000); push(8'h22, 3'b100); push(8'h33, 3'b000);
    run(16);
    check("mix_count", count, 1);
    check("mix_status", status, 3'b100);
`ifdef UART_RX_ERR_DROP_EN
    check("mix_recv_n", recv_d.size(), 2);
    check_recv("mix_recv0", 0, 8'h11, 3'b000);
    check_recv("mix_recv1", 1, 8'h33, 3'b000);
`else
    check("mix_recv_n", recv_d.size(), 3);
    check_recv("mix_recv0", 0, 8'h11, 3'b000);
    check_recv("mix_recv1", 1, 8'h22, 3'b100);
    check_recv("mix_recv2", 2, 8'h33, 3'b000);
`endif

    // Configuration request while a character is held
    recv_d.delete(); recv_e.delete();
    data_ready = 1'b0;
    push(8'h55, 3'b000);
    run(2);
    config_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("cfg_blocked", {cfg_irq, valid}, 2'b01);
    end
    data_ready = 1'b1;
    step();
    check("cfg_enter", {cfg_irq, valid, ack}, 3'b100);
    check_recv("cfg_drained", 0, 8'h55, 3'b000);
    step();
    check("cfg_wait", {cfg_irq, ack}, 2'b10);
    cfg_ack = 1'b1;
    step();
    check("cfg_ack_pulse", {ack, cfg_irq}, 2'b10);
    cfg_ack = 1'b0; config_req = 1'b0;
    step();
    check("cfg_ack_one_cycle", ack, 0);
    check("cfg_ack_cnt", ack_cnt, 1);

    // Request withdrawn before host ack
    config_req = 1'b1;
    step();
    check("wd_irq", cfg_irq, 1);
    step();
    config_req = 1'b0;
    step();
    check("wd_exit", {cfg_irq, ack}, 2'b00);
    run(3);
    check("wd_no_ack", ack_cnt, 1);

    // Configuration has priority over fetch
    recv_d.delete(); recv_e.delete();
    config_req = 1'b1;
    push(8'h66, 3'b000);
    step();
    check("prio_cfg", {rd, cfg_irq}, 2'b01);
    step();
    check("prio_no_read", rd, 0);
    config_req = 1'b0;
    step();
    step();
    check("prio_fetch_after", rd, 1);
    run(4);
    check_recv("prio_recv", 0, 8'h66, 3'b000);

    // Reset mid-operation drops the held character
    data_ready = 1'b0;
    push(8'h77, 3'b000);
    run(2);
    check("rst_held", {valid, data}, {1'b1, 8'h77});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {valid, data, status, count, irq}, 21'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("rst_after", valid, 0);

    check("no_illegal_pop", illegal, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
